// File: rtl/popcnt_tree_sched.sv
// Purpose:      shares one 128-bit popcount adder tree among NREQ requesters with
//               round-robin arbitration and burst lock, and returns one total per burst.
// Latency:      tree_a is combinational with the accept; res_valid rises TREE_LAT+1 cycles
//               after the closing beat is accepted.
// Backpressure: a beat moves only when gnt[i]&req[i]; the owner holds gnt until its last
//               beat, and the result side cannot be stalled.
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   req, last, data      per-requester beat valid, end-of-burst flag, 128-bit beat
//   gnt                  one-hot grant (or zero)
//   tree_a, tree_sum     beat to the adder tree, popcount back TREE_LAT cycles later
//   res_valid/id/count/trunc  burst total pulse, owner id, sum, ended-by-limit flag
module popcnt_tree_sched #(
  parameter int NREQ      = 4,
  parameter int TREE_LAT  = 2,
  parameter int MAX_BURST = 256,
  parameter int ACC_W     = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ-1:0]           last,
  input  logic [NREQ*128-1:0]       data,
  output logic [NREQ-1:0]           gnt,
  output logic [127:0]              tree_a,
  input  logic [7:0]                tree_sum,
  output logic                      res_valid,
  output logic [$clog2(NREQ)-1:0]   res_id,
  output logic [ACC_W-1:0]          res_count,
  output logic                      res_trunc
);

  localparam int ID_W  = $clog2(NREQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BURST} state_t;

  // One tag per tree slot; fin marks the beat that closes its burst.
  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
    logic            fin;
    logic            trunc;
  } tag_t;

  state_t            state, state_n;
  logic [ID_W-1:0]   ptr, ptr_n, owner, owner_n, pick, sel;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              found, accept, at_limit, beat_fin, beat_trunc;
  int                rr_k;

  tag_t              pipe [TREE_LAT];
  tag_t              al;
  logic [ACC_W-1:0]  acc, acc_sum;

  function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] x);
    return (int'(x) == NREQ - 1) ? '0 : x + 1'b1;
  endfunction

  // Round-robin pick: first requester at or above ptr, wrapping around.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    rr_k  = 0;
    for (int i = 0; i < NREQ; i++) begin
      rr_k = int'(ptr) + i;
      if (rr_k >= NREQ) rr_k = rr_k - NREQ;
      if (!found && req[rr_k]) begin
        found = 1'b1;
        pick  = ID_W'(rr_k);
      end
    end
  end

  always_comb begin
    state_n    = state;
    ptr_n      = ptr;
    owner_n    = owner;
    cnt_n      = cnt;
    gnt        = '0;
    sel        = owner;
    at_limit   = 1'b0;
    beat_fin   = 1'b0;
    beat_trunc = 1'b0;
    accept     = 1'b0;
    if (state == IDLE) begin
      sel = pick;
      if (found) gnt[pick] = 1'b1;
      at_limit = (MAX_BURST == 1);
    end else begin
      // Grant stays with the owner even on cycles where it has nothing to send.
      gnt[owner] = 1'b1;
      at_limit   = (int'(cnt) + 1 == MAX_BURST);
    end
    accept = |(gnt & req);
    if (accept) begin
      beat_fin   = last[sel] | at_limit;
      beat_trunc = at_limit & ~last[sel];
      if (beat_fin) begin
        state_n = IDLE;
        ptr_n   = wrap_inc(sel);
        cnt_n   = '0;
      end else begin
        state_n = BURST;
        owner_n = sel;
        cnt_n   = cnt + 1'b1;
      end
    end
  end

  // The tree registers its input, so the beat is presented combinationally.
  always_comb begin
    tree_a = '0;
    if (accept) tree_a = data[int'(sel)*128 +: 128];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
      owner <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      owner <= owner_n;
      cnt   <= cnt_n;
    end
  end

  // Tag pipe mirrors the tree latency; the last stage lines up with tree_sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TREE_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= '{vld: accept, id: sel, fin: beat_fin, trunc: beat_trunc};
      for (int i = 1; i < TREE_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign al      = pipe[TREE_LAT-1];
  assign acc_sum = acc + ACC_W'(tree_sum);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      res_valid <= 1'b0;
      res_id    <= '0;
      res_count <= '0;
      res_trunc <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      if (al.vld) begin
        if (al.fin) begin
          res_valid <= 1'b1;
          res_count <= acc_sum;
          res_id    <= al.id;
          res_trunc <= al.trunc;
          acc       <= '0;
        end else begin
          acc <= acc_sum;
        end
      end
    end
  end

endmodule
